// File: rtl/uvmt_cv32e40s_obi_rsp_scheduler_if.sv
// OBI slave-side handshake bundle for the response scheduler.
// Signal names follow the core's OBI port naming, seen from the scheduler.
interface uvmt_cv32e40s_obi_rsp_scheduler_if #(
    parameter int MAX_OBI_STALLS = 8,
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 32
);
    logic                                  req_i;
    logic                                  gnt_stall_i;
    logic [$clog2(MAX_OBI_STALLS+1)-1:0]   rsp_delay_i;
    logic                                  gnt_o;
    logic                                  rvalid_o;
    logic [CNT_W-1:0]                      rsp_idx_o;
    logic [CNT_W-1:0]                      aph_count_o;
    logic [CNT_W-1:0]                      rph_count_o;
    logic [$clog2(DEPTH+1)-1:0]            outstanding_o;
    logic                                  bound_err_o;

    modport slave (
        input  req_i, gnt_stall_i, rsp_delay_i,
        output gnt_o, rvalid_o, rsp_idx_o, aph_count_o, rph_count_o,
               outstanding_o, bound_err_o
    );

    modport master (
        output req_i, gnt_stall_i, rsp_delay_i,
        input  gnt_o, rvalid_o, rsp_idx_o, aph_count_o, rph_count_o,
               outstanding_o, bound_err_o
    );
endinterface

// File: rtl/uvmt_cv32e40s_obi_rsp_scheduler.sv
// Bench-side OBI slave: grants address phases, queues them in order and returns
// each response after its own clamped delay, with occurrence counters and a bound check.
module uvmt_cv32e40s_obi_rsp_scheduler #(
    parameter int MAX_OBI_STALLS = 8,
    parameter int DEPTH          = 4,
    parameter int CNT_W          = 32
) (
    input logic clk_i,
    input logic rst_ni,
    uvmt_cv32e40s_obi_rsp_scheduler_if.slave bus
);
    localparam int DW = $clog2(MAX_OBI_STALLS + 1);
    localparam int AW = $clog2(MAX_OBI_STALLS + 2);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] L_MAXD    = DW'(MAX_OBI_STALLS);
    localparam logic [AW-1:0] L_MAXA    = AW'(MAX_OBI_STALLS);
    localparam logic [AW-1:0] L_AGE_SAT = AW'(MAX_OBI_STALLS + 1);

    logic [DW-1:0]    r_cnt [DEPTH];
    logic [CNT_W-1:0] r_idx [DEPTH];
    logic [AW-1:0]    r_age [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [OW-1:0]    r_count;
    logic [CNT_W-1:0] r_aph, r_rph, r_rsp_idx;
    logic             r_rvalid, r_bound_err;

    logic             w_full, w_gnt, w_acc, w_bypass, w_push, w_pop, w_late;
    logic [DW-1:0]    w_d;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_full   = (r_count == OW'(DEPTH));
        w_gnt    = !w_full && !bus.gnt_stall_i;
        w_acc    = bus.req_i && w_gnt;
        w_d      = (bus.rsp_delay_i > L_MAXD) ? L_MAXD : bus.rsp_delay_i;
        w_bypass = w_acc && (w_d == '0) && (r_count == '0);
        w_push   = w_acc && !w_bypass;
        w_pop    = r_vld[r_rptr] && (r_cnt[r_rptr] == '0);
        w_late   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_age[i] > L_MAXA)) w_late = 1'b1;
        end
    end

    // Entries store delay-1: the pop edge precedes the rvalid cycle by one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
                r_idx[i] <= '0;
                r_age[i] <= '0;
            end
            r_vld       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_aph       <= '0;
            r_rph       <= '0;
            r_rsp_idx   <= '0;
            r_rvalid    <= 1'b0;
            r_bound_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= (r_cnt[i] != '0) ? r_cnt[i] - DW'(1) : '0;
                r_age[i] <= (r_age[i] == L_AGE_SAT) ? r_age[i] : r_age[i] + AW'(1);
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= f_next(r_rptr);
            end
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_cnt[r_wptr] <= (w_d == '0) ? '0 : w_d - DW'(1);
                r_idx[r_wptr] <= r_aph;
                r_age[r_wptr] <= '0;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_acc) r_aph <= r_aph + CNT_W'(1);
            r_rvalid <= w_pop || w_bypass;
            if (w_pop) begin
                r_rsp_idx <= r_idx[r_rptr];
                r_rph     <= r_rph + CNT_W'(1);
            end else if (w_bypass) begin
                r_rsp_idx <= r_aph;
                r_rph     <= r_rph + CNT_W'(1);
            end
            if (w_push && !w_pop)      r_count <= r_count + OW'(1);
            else if (!w_push && w_pop) r_count <= r_count - OW'(1);
            if (w_late) r_bound_err <= 1'b1;
        end
    end

    assign bus.gnt_o         = w_gnt;
    assign bus.rvalid_o      = r_rvalid;
    assign bus.rsp_idx_o     = r_rsp_idx;
    assign bus.aph_count_o   = r_aph;
    assign bus.rph_count_o   = r_rph;
    assign bus.outstanding_o = r_count;
    assign bus.bound_err_o   = r_bound_err;
endmodule

// File: tb/tb_uvmt_cv32e40s_obi_rsp_scheduler.sv
// Scoreboard bench: expected response cycle per accept is max(c+1+d, previous+1);
// a negedge monitor checks every cycle's outputs against that model.
module tb_uvmt_cv32e40s_obi_rsp_scheduler;
    localparam int MAXS = 8;
    localparam int DEP  = 4;
    localparam int CW   = 6;   // small counters so the run wraps them

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uvmt_cv32e40s_obi_rsp_scheduler_if #(.MAX_OBI_STALLS(MAXS), .DEPTH(DEP), .CNT_W(CW)) bif ();

    uvmt_cv32e40s_obi_rsp_scheduler #(.MAX_OBI_STALLS(MAXS), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bif)
    );

    typedef struct {
        logic [CW-1:0] idx;
        longint        due;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    longint        m_cyc    = 0;
    longint        last_due = 0;
    logic [CW-1:0] m_aph    = '0;
    logic [CW-1:0] m_rph    = '0;
    logic [CW-1:0] m_last   = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rvalid", bif.rvalid_o, 0);
            chk("rst_aph", bif.aph_count_o, 0);
            chk("rst_rph", bif.rph_count_o, 0);
            chk("rst_outstanding", bif.outstanding_o, 0);
            chk("rst_rsp_idx", bif.rsp_idx_o, 0);
            chk("rst_bound_err", bif.bound_err_o, 0);
            chk("rst_gnt", bif.gnt_o, !bif.gnt_stall_i);
            q.delete();
            m_aph    = '0;
            m_rph    = '0;
            m_last   = '0;
            last_due = m_cyc;
        end else begin
            int  d;
            bit  exp_gnt;
            exp_t e;
            if (bif.rvalid_o) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_cycle", m_cyc, e.due);
                    chk("rsp_idx", bif.rsp_idx_o, e.idx);
                    m_rph  = m_rph + 1'b1;
                    m_last = e.idx;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= m_cyc) begin
                    e = q.pop_front();
                    chk("rsp_missing_at_due", m_cyc, e.due + 1);
                    m_rph  = m_rph + 1'b1;
                    m_last = e.idx;
                end
                chk("rsp_idx_hold", bif.rsp_idx_o, m_last);
            end
            chk("rph_count", bif.rph_count_o, m_rph);
            chk("aph_count", bif.aph_count_o, m_aph);
            chk("outstanding", bif.outstanding_o, q.size());
            chk("bound_err", bif.bound_err_o, 0);
            exp_gnt = !bif.gnt_stall_i && (q.size() < DEP);
            chk("gnt", bif.gnt_o, exp_gnt);
            if (bif.req_i && exp_gnt) begin
                d = (int'(bif.rsp_delay_i) > MAXS) ? MAXS : int'(bif.rsp_delay_i);
                e.idx = m_aph;
                e.due = (m_cyc + 1 + d > last_due + 1) ? m_cyc + 1 + d : last_due + 1;
                if (e.due > m_cyc + 1 + MAXS) chk("model_bound", e.due, m_cyc + 1 + MAXS);
                last_due = e.due;
                q.push_back(e);
                m_aph = m_aph + 1'b1;
            end
        end
        m_cyc++;
    end

    task automatic step(input bit req, input bit stall, input int dly);
        @(posedge clk);
        #1;
        bif.req_i       = req;
        bif.gnt_stall_i = stall;
        bif.rsp_delay_i = 4'(dly);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bif.req_i       = 1'b0;
        bif.gnt_stall_i = 1'b0;
        bif.rsp_delay_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        // bypass, max delay, clamped delay
        step(1'b1, 1'b0, 0);  idle(5);
        step(1'b1, 1'b0, 8);  idle(12);
        step(1'b1, 1'b0, 15); idle(12);
        // back-to-back with a blocking head
        step(1'b1, 1'b0, 3); step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 0); step(1'b1, 1'b0, 0);
        idle(10);
        // fill the FIFO with req held high
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8);
        idle(20);
        // grant throttling
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2);
        step(1'b1, 1'b0, 2);
        idle(10);
        // reset with three outstanding
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8);
        idle(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", bif.rvalid_o, 0);
        chk("async_rst_outstanding", bif.outstanding_o, 0);
        idle(2);
        #0 rst_n = 1'b1;
        step(1'b1, 1'b0, 2);
        idle(6);
        // randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15, $urandom_range(0, 15));
        idle(20);
        chk("drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
